ncl4_sync_receiver: RTL and testbench
=====================================

# ncl4_sync_receiver

Clocked receiving end of the four-rail (1-of-4) NCL pipeline. It consumes DATA/NULL wavefronts from the last pipeline stage and drives that stage's completion/acknowledge input in place of the free-running TH14 consumer. It decodes each 1-of-4 symbol to 2 bits and packs SYMS symbols, LSB-first, into a word. Words go into a small FIFO drained by a synchronous valid/ready interface, so downstream stalls propagate back into the NCL pipeline as withheld acknowledges.

## Interface
- SYMS, 4, symbols per output word; word width is 2*SYMS.
- DEPTH, 4, FIFO depth in words; must be a power of 2 and ≥2.
- clk  input  1  sole clock.
- init_n  input  1  asynchronous active-low reset.
- rail_in  input  4  1-of-4 rails from the last NCL stage; asynchronous to clk.
- rail_ack  output  1  completion to the NCL stage. 1 requests NULL, 0 requests DATA (same sense as a stage COMP signal).
- out_data  output  2*SYMS  head-of-FIFO word; symbol 0 is in bits [1:0].
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- sym_err  output  1  sticky; set by any multi-rail DATA symbol.
- fifo_count  output  $clog2(DEPTH)+1  words held.

## Operation
- Each rail passes through a 2-flop synchronizer, giving rs[3:0]. All decisions use rs only.
- Stability filter: a rail pattern is qualified when rs holds the same value on 2 consecutive clk edges.
- States:
  - WAIT_DATA (rail_ack=0): on a qualified non-zero pattern, go to CAPTURE.
  - CAPTURE: exactly one rail high → decode rail k to value k and write it into the assembly slot at sym_idx. Two or more rails high → set sym_err; the symbol is discarded and sym_idx does not advance. Either way go to WAIT_NULL. If this symbol would complete a word (sym_idx==SYMS-1) and fifo_count==DEPTH, stay in CAPTURE with rail_ack=0 until a pop makes space; do not re-sample the rails while stalled.
  - WAIT_NULL (rail_ack=1): on qualified all-zero rs, go to WAIT_DATA.
- Word assembly: a valid capture with sym_idx==SYMS-1 pushes the completed word and sets sym_idx to 0. Otherwise sym_idx increments.
- FIFO: circular buffer with ptr wrap mod DEPTH. Pop occurs when out_valid && out_ready. A push and a pop in the same cycle keep count unchanged. The full check for a push uses the count registered at the start of the cycle, so a same-cycle pop does not unblock a push.
- A partial word is never emitted. It stays in assembly until its SYMS symbols arrive.
- Reset (any time, including mid-wavefront):
  - state=WAIT_DATA, rail_ack=0, sym_idx=0.
  - FIFO emptied, out_valid=0, out_data=0, fifo_count=0, sym_err=0.
  - Synchronizers cleared.
  - The NCL side must be re-initialized by its own init at the same time.

## Timing
- rail_in change to first rs visibility: 2 cycles. Qualification adds 1 cycle, so an edge is qualified 3 clk edges after the rail settles.
- Qualified DATA → CAPTURE on the next edge. rail_ack rises 1 cycle after CAPTURE, on the entry to WAIT_NULL.
- Qualified NULL → rail_ack falls on the next edge.
- Minimum full DATA+NULL cycle as seen from clk: about 8 clk periods per symbol.
- Push → out_valid high on the following edge. out_data is registered and valid whenever out_valid=1.
- rail_ack is a registered output with no combinational path from any input.
- rail_ack changes only in the defined state transitions above. No glitches.

## Test plan
- Reset, then send NULL/DATA on rails 0,1,2,3 in order (SYMS=4) → out_valid after the 4th capture with out_data=8'hE4, sym_err=0. rail_ack toggles 1/0 once per symbol.
- Send 4 words with out_ready=0, then a 5th word's 4th symbol → fifo_count=4 and rail_ack held 0. Raise out_ready for one cycle → one pop, the stalled symbol is captured, rail_ack rises, fifo_count returns to 4.
- Send DATA with rails 0 and 2 both high → sym_err=1 (sticky). The symbol is dropped but rail_ack still completes the cycle. The next 4 legal symbols form one word.
- Drive a one-clock rail pulse shorter than qualification → no capture and rail_ack stays 0.
- Assert init_n low in WAIT_NULL after 2 symbols of a word → all outputs are at reset values immediately. After release, 4 new symbols 3,3,3,3 → out_data=8'hFF.
- Hold out_ready=1 while streaming 10 words → words appear in order, pointer wrap is exercised, and fifo_count stays ≤1.

Source files
------------

// File: rtl/ncl4_sync_receiver.sv
// Clocked receiver for a 1-of-4 NCL pipeline: synchronizes and qualifies rail
// wavefronts, packs decoded symbols into words, and buffers them in a ready/valid FIFO.
module ncl4_sync_receiver #(
    parameter int unsigned SYMS  = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     init_n,
    input  logic [3:0]               rail_in,
    output logic                     rail_ack,
    output logic [2*SYMS-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     sym_err,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int unsigned IW = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WW = 2 * SYMS;

    typedef enum logic [1:0] {
        S_WAIT_DATA,
        S_CAPTURE,
        S_WAIT_NULL
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_sync1;
    logic [3:0]      r_rs;
    logic [3:0]      r_rs_prev;
    logic [3:0]      r_sym;
    logic            r_ack;
    logic            r_err;
    logic [IW-1:0]   r_idx;
    logic [WW-1:0]   r_asm;
    logic [WW-1:0]   r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_count;

    logic            w_qual;
    logic            w_onehot;
    logic            w_last;
    logic            w_full;
    logic            w_pop;
    logic            w_cap;
    logic            w_push;
    logic            w_bad;
    logic [1:0]      w_dec;
    logic [WW-1:0]   w_word;

    assign w_qual    = (r_rs == r_rs_prev);
    assign w_onehot  = (r_sym != 4'b0000) && ((r_sym & (r_sym - 4'd1)) == 4'b0000);
    assign w_last    = (r_idx == IW'(SYMS - 1));
    assign w_full    = (r_count == (PW+1)'(DEPTH));
    assign w_pop     = out_valid && out_ready;

    assign rail_ack   = r_ack;
    assign sym_err    = r_err;
    assign out_valid  = (r_count != '0);
    assign out_data   = r_mem[r_rptr];
    assign fifo_count = r_count;

    always_comb begin
        w_dec = 2'd0;
        case (r_sym)
            4'b0010: w_dec = 2'd1;
            4'b0100: w_dec = 2'd2;
            4'b1000: w_dec = 2'd3;
            default: w_dec = 2'd0;
        endcase
    end

    // The pushed word must already contain the symbol being captured this cycle.
    always_comb begin
        w_word = r_asm;
        w_word[{r_idx, 1'b0} +: 2] = w_dec;
    end

    always_comb begin
        w_next = r_state;
        w_cap  = 1'b0;
        w_push = 1'b0;
        w_bad  = 1'b0;
        case (r_state)
            S_WAIT_DATA: begin
                if (w_qual && (r_rs != 4'b0000)) w_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                if (!w_onehot) begin
                    w_bad  = 1'b1;
                    w_next = S_WAIT_NULL;
                end else if (!(w_last && w_full)) begin
                    w_cap  = 1'b1;
                    w_push = w_last;
                    w_next = S_WAIT_NULL;
                end
            end
            S_WAIT_NULL: begin
                if (w_qual && (r_rs == 4'b0000)) w_next = S_WAIT_DATA;
            end
            default: w_next = S_WAIT_DATA;
        endcase
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            r_sync1   <= '0;
            r_rs      <= '0;
            r_rs_prev <= '0;
            r_state   <= S_WAIT_DATA;
            r_ack     <= 1'b0;
            r_sym     <= '0;
            r_err     <= 1'b0;
            r_idx     <= '0;
            r_asm     <= '0;
        end else begin
            r_sync1   <= rail_in;
            r_rs      <= r_sync1;
            r_rs_prev <= r_rs;
            r_state   <= w_next;
            r_ack     <= (w_next == S_WAIT_NULL);
            // Latch the pattern once so a stalled capture never re-reads the rails.
            if ((r_state == S_WAIT_DATA) && (w_next == S_CAPTURE)) r_sym <= r_rs;
            if (w_bad) r_err <= 1'b1;
            if (w_cap) begin
                r_asm <= w_word;
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_word;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PW+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (PW+1)'(1);
        end
    end

endmodule

// File: tb/tb_ncl4_sync_receiver.sv
// Directed self-checking bench for ncl4_sync_receiver (SYMS=4, DEPTH=4).
module tb_ncl4_sync_receiver;

    logic       clk = 1'b0;
    logic       init_n;
    logic [3:0] rail_in;
    logic       rail_ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       sym_err;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;

    logic       mon_en = 1'b0;
    logic [7:0] popq[$];
    int         maxcnt = 0;

    ncl4_sync_receiver #(.SYMS(4), .DEPTH(4)) dut (
        .clk       (clk),
        .init_n    (init_n),
        .rail_in   (rail_in),
        .rail_ack  (rail_ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sym_err   (sym_err),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            if (out_valid && out_ready) popq.push_back(out_data);
            if (int'(fifo_count) > maxcnt) maxcnt = int'(fifo_count);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input logic val, input int maxc, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(posedge clk);
            #1;
            if (rail_ack === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic send(input logic [3:0] pat, input string tag);
        logic ok;
        rail_in = pat;
        wait_ack(1'b1, 20, ok);
        chk({tag, "_ack_rise"}, ok, 1);
        rail_in = 4'b0000;
        wait_ack(1'b0, 20, ok);
        chk({tag, "_ack_fall"}, ok, 1);
    endtask

    task automatic send_word(input logic [7:0] w, input string tag);
        logic [1:0] s;
        for (int i = 0; i < 4; i++) begin
            s = w[2*i +: 2];
            send(4'b0001 << s, tag);
        end
    endtask

    task automatic pop_check(input logic [7:0] exp, input string tag);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_data"}, out_data, exp);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"}, rail_ack, 0);
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_data"}, out_data, 8'h00);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_err"}, sym_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic       ok;
    logic [7:0] stream [10] = '{8'h1B, 8'hE4, 8'h00, 8'hFF, 8'h55,
                                8'hAA, 8'h39, 8'hC6, 8'h72, 8'h8D};

    initial begin
        init_n    = 1'b0;
        rail_in   = 4'b0000;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        init_n = 1'b1;
        repeat (2) @(posedge clk);

        // Rails 0..3 in order -> word E4
        send(4'b0001, "t1_s0");
        send(4'b0010, "t1_s1");
        send(4'b0100, "t1_s2");
        chk("t1_partial_valid", out_valid, 0);
        send(4'b1000, "t1_s3");
        chk("t1_count", fifo_count, 1);
        chk("t1_err", sym_err, 0);
        pop_check(8'hE4, "t1_word");
        chk("t1_count_after_pop", fifo_count, 0);

        // Fill FIFO, then stall on the 4th symbol of a 5th word
        send_word(8'hE4, "t2_w0");
        send_word(8'h1B, "t2_w1");
        send_word(8'h55, "t2_w2");
        send_word(8'hAA, "t2_w3");
        chk("t2_full_count", fifo_count, 4);
        send(4'b0001, "t2_w4s0");
        send(4'b0001, "t2_w4s1");
        send(4'b0001, "t2_w4s2");
        rail_in = 4'b1000;
        repeat (12) @(posedge clk);
        #1;
        chk("t2_stall_ack", rail_ack, 0);
        chk("t2_stall_count", fifo_count, 4);
        pop_check(8'hE4, "t2_pop0");
        wait_ack(1'b1, 10, ok);
        chk("t2_unstall_ack", ok, 1);
        chk("t2_refill_count", fifo_count, 4);
        rail_in = 4'b0000;
        wait_ack(1'b0, 20, ok);
        chk("t2_null_ack", ok, 1);
        pop_check(8'h1B, "t2_pop1");
        pop_check(8'h55, "t2_pop2");
        pop_check(8'hAA, "t2_pop3");
        pop_check(8'hC0, "t2_pop4");
        chk("t2_drained", fifo_count, 0);

        // Multi-rail symbol: sticky error, symbol dropped
        send(4'b0101, "t3_bad");
        chk("t3_err", sym_err, 1);
        chk("t3_no_word", fifo_count, 0);
        send(4'b0010, "t3_s0");
        send(4'b0010, "t3_s1");
        send(4'b0100, "t3_s2");
        send(4'b0001, "t3_s3");
        chk("t3_count", fifo_count, 1);
        chk("t3_err_sticky", sym_err, 1);
        pop_check(8'h25, "t3_word");

        // One-clock glitch must not be qualified
        @(negedge clk);
        rail_in = 4'b0010;
        @(negedge clk);
        rail_in = 4'b0000;
        repeat (10) @(posedge clk);
        #1;
        chk("t4_glitch_ack", rail_ack, 0);
        chk("t4_glitch_count", fifo_count, 0);

        // Reset mid-word with a word still queued
        send_word(8'h55, "t5_pre");
        chk("t5_pre_count", fifo_count, 1);
        send(4'b0001, "t5_s0");
        rail_in = 4'b0010;
        wait_ack(1'b1, 20, ok);
        chk("t5_in_null", ok, 1);
        #3;
        init_n  = 1'b0;
        rail_in = 4'b0000;
        #1;
        check_reset_outputs("t5_async");
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        repeat (2) @(posedge clk);
        send_word(8'hFF, "t5_post");
        chk("t5_post_count", fifo_count, 1);
        pop_check(8'hFF, "t5_word");

        // Streaming with out_ready held high
        popq.delete();
        maxcnt = 0;
        @(negedge clk);
        out_ready = 1'b1;
        mon_en    = 1'b1;
        for (int i = 0; i < 10; i++) send_word(stream[i], "t6");
        repeat (4) @(posedge clk);
        #1;
        mon_en = 1'b0;
        out_ready = 1'b0;
        chk("t6_nwords", popq.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < popq.size()) chk($sformatf("t6_word%0d", i), popq[i], stream[i]);
        end
        chk("t6_maxcnt_le1", (maxcnt <= 1), 1);
        chk("t6_final_count", fifo_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
